// File: rtl/regfile_stream_reader.sv
// Read-side sequencer for the shared-output register file. It walks a wrapping
// range of rows, settles each select, captures the muxed row and offers it on valid/ready.
module regfile_stream_reader #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 16,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned CNT_W  = 5,
    parameter int unsigned SETTLE = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [IDX_W-1:0] StartRow,
    input  logic [CNT_W-1:0] Count,
    input  logic             Abort,
    output logic [IDX_W-1:0] Sel,
    input  logic [WIDTH-1:0] RdData,
    output logic [WIDTH-1:0] DataOut,
    output logic [IDX_W-1:0] RowOut,
    output logic             Valid,
    input  logic             Ready,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    localparam int unsigned SET_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_OFFER,
        S_FINISH
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  row;
    logic [CNT_W-1:0]  remaining;
    logic [SET_W-1:0]  settle_cnt;

    logic              row_ok;
    logic              cnt_ok;
    logic              cnt_zero;
    logic [IDX_W-1:0]  next_row;
    logic              last_beat;

    // Request legality and wrapping row successor.
    assign row_ok    = 32'(StartRow) < HEIGHT;
    assign cnt_ok    = 32'(Count) <= HEIGHT;
    assign cnt_zero  = (Count == '0);
    assign next_row  = (row == IDX_W'(HEIGHT - 1)) ? '0 : row + IDX_W'(1);
    assign last_beat = (remaining == CNT_W'(1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= S_IDLE;
            row        <= '0;
            remaining  <= '0;
            settle_cnt <= '0;
            Sel        <= '0;
            DataOut    <= '0;
            RowOut     <= '0;
            Valid      <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Err        <= 1'b0;
        end else begin
            Done <= 1'b0;
            Err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (!row_ok || !cnt_ok) begin
                            Err <= 1'b1;
                        end else if (cnt_zero) begin
                            Done <= 1'b1;
                        end else begin
                            row        <= StartRow;
                            remaining  <= Count;
                            Sel        <= StartRow;
                            settle_cnt <= SET_W'(SETTLE);
                            Busy       <= 1'b1;
                            state      <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (Abort) begin
                        Busy  <= 1'b0;
                        Valid <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                        // Capture on the edge where the settle count reaches zero.
                        if (settle_cnt == SET_W'(1)) begin
                            DataOut <= RdData;
                            RowOut  <= row;
                            Valid   <= 1'b1;
                            state   <= S_OFFER;
                        end
                    end
                end
                S_OFFER: begin
                    if (Abort) begin
                        Busy  <= 1'b0;
                        Valid <= 1'b0;
                        state <= S_IDLE;
                    end else if (Ready) begin
                        Valid     <= 1'b0;
                        remaining <= remaining - CNT_W'(1);
                        row       <= next_row;
                        if (last_beat) begin
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            Sel        <= next_row;
                            settle_cnt <= SET_W'(SETTLE);
                            state      <= S_SETTLE;
                        end
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_stream_reader.sv
// Bench for regfile_stream_reader: directed scenarios plus randomized bursts checked
// every cycle against a queue-based model of which rows must come out and when.
module tb_regfile_stream_reader;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 16;
    localparam int unsigned IW = 4;
    localparam int unsigned CW = 5;
    localparam int unsigned ST = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, abort, ready;
    logic [IW-1:0] start_row, sel, row_out;
    logic [CW-1:0] count;
    logic [W-1:0]  rd_data, data_out;
    logic          valid, busy, done, err;

    logic          start3, abort3, ready3;
    logic [IW-1:0] start_row3, sel3, row_out3;
    logic [CW-1:0] count3;
    logic [W-1:0]  rd_data3, data_out3;
    logic          valid3, busy3, done3, err3;

    logic [W-1:0] mem [16];
    assign rd_data  = mem[sel];
    assign rd_data3 = mem[sel3];

    regfile_stream_reader #(.WIDTH(W), .HEIGHT(H), .IDX_W(IW), .CNT_W(CW), .SETTLE(ST)) dut (
        .Clk(clk), .Rst(rst), .Start(start), .StartRow(start_row), .Count(count),
        .Abort(abort), .Sel(sel), .RdData(rd_data), .DataOut(data_out), .RowOut(row_out),
        .Valid(valid), .Ready(ready), .Busy(busy), .Done(done), .Err(err)
    );

    regfile_stream_reader #(.WIDTH(W), .HEIGHT(12), .IDX_W(IW), .CNT_W(CW), .SETTLE(3)) dut3 (
        .Clk(clk), .Rst(rst), .Start(start3), .StartRow(start_row3), .Count(count3),
        .Abort(abort3), .Sel(sel3), .RdData(rd_data3), .DataOut(data_out3), .RowOut(row_out3),
        .Valid(valid3), .Ready(ready3), .Busy(busy3), .Done(done3), .Err(err3)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;
    int cyc      = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Model: the pending rows of a burst as a queue, a wait count until the next offer.
    bit            m_active, m_fin, m_valid, m_busy, m_done, m_err;
    int            m_wait;
    int            m_q[$];
    logic [IW-1:0] m_sel = '0;
    logic [IW-1:0] m_row = '0;
    logic [W-1:0]  m_data = '0;

    always @(posedge clk) begin
        cyc++;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            m_active = 1'b0; m_fin = 1'b0; m_valid = 1'b0; m_busy = 1'b0;
            m_sel = '0; m_row = '0; m_data = '0;
            m_q.delete();
        end else if (m_fin) begin
            m_fin = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                if (32'(start_row) >= H || 32'(count) > H) begin
                    m_err = 1'b1;
                end else if (count == '0) begin
                    m_done = 1'b1;
                end else begin
                    m_q.delete();
                    for (int i = 0; i < int'(count); i++)
                        m_q.push_back(int'((32'(start_row) + 32'(i)) % H));
                    m_active = 1'b1;
                    m_busy   = 1'b1;
                    m_sel    = IW'(m_q[0]);
                    m_wait   = int'(ST);
                end
            end
        end else if (abort) begin
            m_active = 1'b0; m_busy = 1'b0; m_valid = 1'b0;
        end else if (m_valid) begin
            if (ready) begin
                void'(m_q.pop_front());
                m_valid = 1'b0;
                if (m_q.size() == 0) begin
                    m_active = 1'b0; m_busy = 1'b0; m_done = 1'b1; m_fin = 1'b1;
                end else begin
                    m_sel  = IW'(m_q[0]);
                    m_wait = int'(ST);
                end
            end
        end else begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1'b1;
                m_data  = mem[m_sel];
                m_row   = IW'(m_q[0]);
            end
        end
    end

    // Beat / pulse log used by the directed scenarios.
    int beat_row[$];
    int beat_data[$];
    int beat_cyc[$];
    int done_cnt, err_cnt, first_valid;

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid",    32'(valid),    32'(m_valid));
            check("busy",     32'(busy),     32'(m_busy));
            check("done",     32'(done),     32'(m_done));
            check("err",      32'(err),      32'(m_err));
            check("sel",      32'(sel),      32'(m_sel));
            check("row_out",  32'(row_out),  32'(m_row));
            check("data_out", 32'(data_out), 32'(m_data));
            if (valid && ready && !abort) begin
                beat_row.push_back(int'(row_out));
                beat_data.push_back(int'(data_out));
                beat_cyc.push_back(cyc);
            end
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (valid && first_valid < 0) first_valid = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        beat_row.delete(); beat_data.delete(); beat_cyc.delete();
        done_cnt = 0; err_cnt = 0; first_valid = -1;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((busy || done) && n < max);
        check("wait_idle_bound", 32'(n >= max), 32'(0));
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!valid && n < max) begin
            tick();
            n++;
        end
        check("wait_valid_bound", 32'(n >= max), 32'(0));
    endtask

    task automatic pulse_start(input int row, input int cnt);
        start_row = IW'(row);
        count     = CW'(cnt);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n;
        int exp_rows[4];
        rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0; start_row = '0; count = '0;
        start3 = 1'b0; abort3 = 1'b0; ready3 = 1'b1; start_row3 = '0; count3 = '0;
        for (int r = 0; r < 16; r++) mem[r] = W'(8'h10 + r);
        first_valid = -1;
        tick();
        tick();
        chk_en = 1'b1;
        rst = 1'b0;
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sel", 32'(sel), 0);
        check("rst_data", 32'(data_out), 0);
        check("rst_done", 32'(done), 0);

        // Basic burst of four rows from row 3.
        clear_log();
        ready = 1'b1;
        t0 = cyc;
        pulse_start(3, 4);
        wait_idle(100);
        check("t1_beats", 32'(beat_row.size()), 4);
        for (int i = 0; i < 4 && i < beat_row.size(); i++) begin
            check("t1_row", 32'(beat_row[i]), 32'(3 + i));
            check("t1_data", 32'(beat_data[i]), 32'(8'h13 + i));
            if (i > 0) check("t1_spacing", 32'(beat_cyc[i] - beat_cyc[i-1]), 2);
        end
        check("t1_first_valid", 32'(first_valid - t0), 2);
        check("t1_done", 32'(done_cnt), 1);

        // Wrap past the last row.
        clear_log();
        exp_rows = '{14, 15, 0, 1};
        pulse_start(14, 4);
        wait_idle(100);
        check("t2_beats", 32'(beat_row.size()), 4);
        for (int i = 0; i < 4 && i < beat_row.size(); i++) begin
            check("t2_row", 32'(beat_row[i]), 32'(exp_rows[i]));
            check("t2_data", 32'(beat_data[i]), 32'(8'h10 + exp_rows[i]));
        end

        // Back-pressure on beat 2.
        clear_log();
        ready = 1'b0;
        pulse_start(3, 4);
        wait_valid(20);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_valid", 32'(valid), 1);
            check("t3_hold_sel", 32'(sel), 4);
            check("t3_hold_row", 32'(row_out), 4);
            check("t3_hold_data", 32'(data_out), 32'h14);
        end
        check("t3_beats_held", 32'(beat_row.size()), 1);
        ready = 1'b1;
        wait_idle(100);
        check("t3_beats", 32'(beat_row.size()), 4);
        check("t3_done", 32'(done_cnt), 1);

        // Zero-length and rejected requests.
        clear_log();
        pulse_start(5, 0);
        check("t4_zero_done", 32'(done), 1);
        check("t4_zero_busy", 32'(busy), 0);
        tick();
        check("t4_zero_done_end", 32'(done), 0);
        pulse_start(2, 17);
        check("t4_err", 32'(err), 1);
        check("t4_err_done", 32'(done), 0);
        tick();
        check("t4_err_end", 32'(err), 0);
        check("t4_no_valid", 32'(first_valid), 32'(-1));
        start_row3 = 4'd12; count3 = 5'd1; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check("t4_row_err", 32'(err3), 1);
        check("t4_row_err_valid", 32'(valid3), 0);
        check("t4_row_err_done", 32'(done3), 0);
        tick();
        check("t4_row_err_end", 32'(err3), 0);

        // Abort coinciding with the third handshake, then an immediate restart.
        clear_log();
        ready = 1'b1;
        pulse_start(0, 4);
        n = 0;
        while (!(valid && beat_row.size() == 2) && n < 50) begin
            tick();
            n++;
        end
        check("t5_bound", 32'(n >= 50), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_busy", 32'(busy), 0);
        check("t5_valid", 32'(valid), 0);
        check("t5_done", 32'(done), 0);
        pulse_start(8, 1);
        check("t5_restart_busy", 32'(busy), 1);
        check("t5_restart_sel", 32'(sel), 8);
        wait_idle(50);
        check("t5_beats", 32'(beat_row.size()), 3);
        if (beat_row.size() == 3) check("t5_last_row", 32'(beat_row[2]), 8);
        check("t5_done_cnt", 32'(done_cnt), 1);

        // Reset while a beat is being offered.
        ready = 1'b0;
        pulse_start(2, 3);
        wait_valid(20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid", 32'(valid), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_sel", 32'(sel), 0);
        check("t6_row", 32'(row_out), 0);
        check("t6_data", 32'(data_out), 0);

        // Longer settle: Valid four cycles after the Start cycle.
        t0 = cyc;
        start_row3 = 4'd5; count3 = 5'd1; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        n = 0;
        while (!valid3 && n < 20) begin
            tick();
            n++;
        end
        check("t7_latency", 32'(cyc - t0), 4);
        check("t7_data", 32'(data_out3), 32'h15);
        check("t7_row", 32'(row_out3), 5);
        tick();
        check("t7_done", 32'(done3), 1);
        tick();

        // Randomized bursts with random back-pressure, aborts and stray starts.
        for (int b = 0; b < 40; b++) begin
            for (int r = 0; r < 16; r++) mem[r] = W'($urandom_range(0, 255));
            ready = 1'b0;
            pulse_start(int'($urandom_range(0, 15)), int'($urandom_range(0, 18)));
            n = 0;
            while ((busy || done) && n < 500) begin
                ready     = ($urandom_range(0, 3) != 0);
                abort     = ($urandom_range(0, 40) == 0);
                start     = ($urandom_range(0, 15) == 0);
                start_row = IW'($urandom_range(0, 15));
                count     = CW'($urandom_range(0, 16));
                tick();
                n++;
            end
            start = 1'b0; abort = 1'b0; ready = 1'b0;
            check("rand_bound", 32'(n >= 500), 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
